sha256_iter_core: RTL and testbench



---
 rtl/sha256_pkg.sv | 63 ++++++
 rtl/sha256_round.sv | 26 ++
 rtl/sha256_iter_core.sv | 115 +++++++++++
 tb/tb_sha256_iter_core.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sha256_pkg : SHA-256 types, round constants, IV and bit-mixing functions
// rev 1.0
// ---------------------------------------------------------------------------
package sha256_pkg;

  typedef logic [31:0] word_t;
  // Element 0 is a / H0 and lands in the MSBs when the state is flattened.
  typedef logic [0:7][31:0] hash_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } fsm_state_t;

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam hash_state_t IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_round.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sha256_round : one combinational SHA-256 compression round
// rev 1.0
// ---------------------------------------------------------------------------
module sha256_round
  import sha256_pkg::*;
(
  input  hash_state_t st_in,
  input  word_t       k,
  input  word_t       w,
  output hash_state_t st_out
);

  word_t t1;
  word_t t2;

  always_comb begin
    t1 = st_in[7] + big_sigma1(st_in[4]) + ch(st_in[4], st_in[5], st_in[6]) + k + w;
    t2 = big_sigma0(st_in[0]) + maj(st_in[0], st_in[1], st_in[2]);
    st_out = {t1 + t2, st_in[0], st_in[1], st_in[2],
              st_in[3] + t1, st_in[4], st_in[5], st_in[6]};
  end

endmodule
`default_nettype wire

// File: rtl/sha256_iter_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sha256_iter_core : iterative SHA-256 block compression, R rounds per clock
// rev 1.0
// ---------------------------------------------------------------------------
module sha256_iter_core
  import sha256_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic         blk_first,
  input  logic [511:0] blk_data,
  output logic         busy,
  output logic         digest_valid,
  output logic [255:0] digest
);

  localparam int R = ROUNDS_PER_CYCLE;

  if (!(R == 1 || R == 2 || R == 4 || R == 8 || R == 16)) begin : g_bad_rounds
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  typedef logic [0:15][31:0]    win_t;
  typedef logic [0:15+R][31:0]  ext_t;

  fsm_state_t  state;
  logic [5:0]  rnd;
  win_t        win;
  hash_state_t work;
  hash_state_t base;
  hash_state_t h_reg;
  ext_t        ext;
  hash_state_t round_out;

  // Words 0..R-1 feed this cycle's rounds; words R..R+15 become the next window.
  function automatic ext_t expand(input win_t w);
    ext_t x;
    x = '0;
    for (int i = 0; i < 16; i++) x[i] = w[i];
    for (int i = 16; i < 16 + R; i++)
      x[i] = small_sigma1(x[i-2]) + x[i-7] + small_sigma0(x[i-15]) + x[i-16];
    return x;
  endfunction

  assign ext = expand(win);

  for (genvar j = 0; j < R; j++) begin : g_round
    hash_state_t st_in;
    hash_state_t st_out;
    if (j == 0) begin : g_first
      assign st_in = work;
    end else begin : g_chain
      assign st_in = g_round[j-1].st_out;
    end
    sha256_round u_round (
      .st_in  (st_in),
      .k      (K[rnd + 6'(j)]),
      .w      (ext[j]),
      .st_out (st_out)
    );
  end

  assign round_out = g_round[R-1].st_out;
  assign digest    = h_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      blk_ready    <= 1'b1;
      busy         <= 1'b0;
      digest_valid <= 1'b0;
      h_reg        <= IV;
      rnd          <= '0;
      win          <= '0;
      work         <= '0;
      base         <= '0;
    end else begin
      digest_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (blk_valid && blk_ready) begin
            win       <= blk_data;
            work      <= blk_first ? IV : h_reg;
            base      <= blk_first ? IV : h_reg;
            rnd       <= '0;
            state     <= RUN;
            blk_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          work <= round_out;
          for (int i = 0; i < 16; i++) win[i] <= ext[i+R];
          rnd <= rnd + 6'(R);
          if (rnd == 6'(64 - R)) state <= FIN;
        end
        FIN: begin
          for (int i = 0; i < 8; i++) h_reg[i] <= base[i] + work[i];
          digest_valid <= 1'b1;
          blk_ready    <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha256_iter_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sha256_iter_core : randomized and known-vector checks against a SHA-256 model
// rev 1.0
// ---------------------------------------------------------------------------
module tb_sha256_iter_core;

  localparam int NDUT = 5;

  localparam logic [255:0] IV_H    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_H   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_H = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_H   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO_BLK1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_BLK2  = {480'h0, 32'h000001c0};

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic         blk_valid = 1'b0;
  logic         blk_first = 1'b0;
  logic [511:0] blk_data  = '0;

  logic         rdy [NDUT];
  logic         bsy [NDUT];
  logic         dv  [NDUT];
  logic [255:0] dg  [NDUT];

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Instance g runs 2**g rounds per clock; instance 0 is the R = 1 core.
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    sha256_iter_core #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .blk_valid    (blk_valid),
      .blk_ready    (rdy[g]),
      .blk_first    (blk_first),
      .blk_data     (blk_data),
      .busy         (bsy[g]),
      .digest_valid (dv[g]),
      .digest       (dg[g])
    );
  end

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256 compression over a full 64-word schedule.
  function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] hout;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
           + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) hout[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
    return hout;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int k = 0; k < 16; k++) b[511 - 32*k -: 32] = $urandom();
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    blk_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Present one block for a single edge (the accept edge, edge 0).
  task automatic send_block(input logic [511:0] b, input logic first);
    blk_data  = b;
    blk_first = first;
    blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
  endtask

  // Edge index (after the accept edge) at which instance 0 pulses digest_valid; -1 on timeout.
  task automatic wait_dv(output int ed);
    ed = -1;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (dv[0]) begin
        ed = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    pulse_reset();
    n_vec++; if (rdy[0] !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", rdy[0]); end
    n_vec++; if (bsy[0] !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bsy[0]); end
    n_vec++; if (dv[0] !== 1'b0) begin n_fail++; $display("FAIL reset_dv: got %b expected 0", dv[0]); end
    n_vec++; if (dg[0] !== IV_H) begin n_fail++; $display("FAIL reset_digest: got %h expected %h", dg[0], IV_H); end
  endtask

  task automatic test_abc();
    int ed;
    send_block(ABC_BLK, 1'b1);
    wait_dv(ed);
    n_vec++; if (ed != 65) begin n_fail++; $display("FAIL abc_dv_edge: got %0d expected 65", ed); end
    n_vec++; if (dg[0] !== ABC_H) begin n_fail++; $display("FAIL abc_digest: got %h expected %h", dg[0], ABC_H); end
    n_vec++; if (rdy[0] !== 1'b1) begin n_fail++; $display("FAIL abc_ready_at_fin: got %b expected 1", rdy[0]); end
    tick();
    n_vec++; if (dv[0] !== 1'b0) begin n_fail++; $display("FAIL abc_dv_pulse_width: got %b expected 0", dv[0]); end
    n_vec++; if (dg[0] !== ABC_H) begin n_fail++; $display("FAIL abc_digest_hold: got %h expected %h", dg[0], ABC_H); end
  endtask

  task automatic test_empty_all_r();
    int dv_edge [NDUT];
    int low_cnt [NDUT];
    logic [255:0] got [NDUT];
    pulse_reset();
    for (int j = 0; j < NDUT; j++) begin dv_edge[j] = -1; low_cnt[j] = 0; got[j] = '0; end
    send_block(EMPTY_BLK, 1'b1);
    for (int n = 0; n <= 70; n++) begin
      if (n > 0) tick();
      for (int j = 0; j < NDUT; j++) begin
        if (!rdy[j]) low_cnt[j]++;
        if (dv[j] && dv_edge[j] < 0) begin dv_edge[j] = n; got[j] = dg[j]; end
      end
    end
    for (int j = 0; j < NDUT; j++) begin
      n_vec++;
      if (dv_edge[j] != 64 / (1 << j) + 1) begin
        n_fail++; $display("FAIL empty_dv_edge R=%0d: got %0d expected %0d", 1 << j, dv_edge[j], 64 / (1 << j) + 1);
      end
      n_vec++;
      if (low_cnt[j] != 64 / (1 << j) + 1) begin
        n_fail++; $display("FAIL empty_ready_low R=%0d: got %0d expected %0d", 1 << j, low_cnt[j], 64 / (1 << j) + 1);
      end
      n_vec++;
      if (got[j] !== EMPTY_H) begin
        n_fail++; $display("FAIL empty_digest R=%0d: got %h expected %h", 1 << j, got[j], EMPTY_H);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    int ed;
    logic rb;
    logic [255:0] got1;
    logic [255:0] exp1;
    acc  = -1;
    got1 = '0;
    exp1 = ref_compress(IV_H, TWO_BLK1);
    pulse_reset();
    blk_data  = TWO_BLK1;
    blk_first = 1'b1;
    blk_valid = 1'b1;
    tick();
    blk_data  = TWO_BLK2;
    blk_first = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      rb = rdy[0];
      tick();
      if (dv[0]) got1 = dg[0];
      if (rb) begin acc = n; break; end
    end
    blk_valid = 1'b0;
    n_vec++; if (acc != 66) begin n_fail++; $display("FAIL b2b_second_accept: got %0d expected 66", acc); end
    n_vec++; if (got1 !== exp1) begin n_fail++; $display("FAIL b2b_first_digest: got %h expected %h", got1, exp1); end
    wait_dv(ed);
    n_vec++; if (ed != 65) begin n_fail++; $display("FAIL b2b_dv_edge: got %0d expected 65", ed); end
    n_vec++; if (dg[0] !== TWO_H) begin n_fail++; $display("FAIL b2b_digest: got %h expected %h", dg[0], TWO_H); end
  endtask

  task automatic test_hold_busy();
    int ed;
    int extra;
    logic rb;
    logic [511:0] x;
    logic [255:0] expx;
    pulse_reset();
    x     = rand_block();
    expx  = ref_compress(IV_H, x);
    ed    = -1;
    extra = 0;
    blk_data  = x;
    blk_first = 1'b1;
    blk_valid = 1'b1;
    tick();
    for (int n = 1; n <= 200; n++) begin
      blk_data  = rand_block();
      blk_first = 1'($urandom_range(0, 1));
      rb = rdy[0];
      tick();
      if (rb) extra++;
      if (dv[0]) begin ed = n; break; end
    end
    blk_valid = 1'b0;
    n_vec++; if (ed != 65) begin n_fail++; $display("FAIL hold_dv_edge: got %0d expected 65", ed); end
    n_vec++; if (extra != 0) begin n_fail++; $display("FAIL hold_extra_accepts: got %0d expected 0", extra); end
    n_vec++; if (dg[0] !== expx) begin n_fail++; $display("FAIL hold_digest: got %h expected %h", dg[0], expx); end
    tick();
    n_vec++; if (bsy[0] !== 1'b0) begin n_fail++; $display("FAIL hold_idle_after: got %b expected 0", bsy[0]); end
  endtask

  task automatic test_reset_midrun();
    int ed;
    int seen;
    pulse_reset();
    send_block(ABC_BLK, 1'b1);
    repeat (29) tick();
    n_vec++; if (bsy[0] !== 1'b1) begin n_fail++; $display("FAIL midrun_busy_before: got %b expected 1", bsy[0]); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++; if (rdy[0] !== 1'b1) begin n_fail++; $display("FAIL midrun_ready: got %b expected 1", rdy[0]); end
    n_vec++; if (bsy[0] !== 1'b0) begin n_fail++; $display("FAIL midrun_busy: got %b expected 0", bsy[0]); end
    n_vec++; if (dv[0] !== 1'b0) begin n_fail++; $display("FAIL midrun_dv: got %b expected 0", dv[0]); end
    n_vec++; if (dg[0] !== IV_H) begin n_fail++; $display("FAIL midrun_digest: got %h expected %h", dg[0], IV_H); end
    seen = 0;
    for (int n = 0; n < 70; n++) begin
      tick();
      if (dv[0]) seen++;
    end
    n_vec++; if (seen != 0) begin n_fail++; $display("FAIL midrun_stray_dv: got %0d pulses expected 0", seen); end
    send_block(ABC_BLK, 1'b0);
    wait_dv(ed);
    n_vec++; if (dg[0] !== ABC_H) begin n_fail++; $display("FAIL midrun_abc_chain_iv: got %h expected %h", dg[0], ABC_H); end
  endtask

  task automatic test_random();
    logic [255:0] model_h;
    logic [255:0] exp_h;
    logic [511:0] b;
    logic first;
    int ed;
    pulse_reset();
    model_h = IV_H;
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      b     = rand_block();
      first = ($urandom_range(0, 3) == 0);
      exp_h = ref_compress(first ? IV_H : model_h, b);
      send_block(b, first);
      wait_dv(ed);
      n_vec++; if (ed != 65) begin n_fail++; $display("FAIL rand_dv_edge[%0d]: got %0d expected 65", i, ed); end
      for (int j = 0; j < NDUT; j++) begin
        n_vec++;
        if (dg[j] !== exp_h) begin
          n_fail++; $display("FAIL rand_digest[%0d] R=%0d: got %h expected %h", i, 1 << j, dg[j], exp_h);
        end
      end
      model_h = exp_h;
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty_all_r();
    test_back_to_back();
    test_hold_busy();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
